// File: rtl/dpram_stream_drain_if.sv
// Valid/ready stream carrying drained DPRAM words toward the readout link.
// The master drives data/valid/last and the slave returns ready.
interface dpram_stream_drain_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dpram_stream_drain.sv
// Consumer side of the DPRAM handoff: on dpram_run, reads dpram_len words from
// DPRAM port B starting at address 0 and forwards them on a valid/ready stream.
// Read data lands in a small skid FIFO. Reads are only issued when the FIFO is
// sure to have room, so back-pressure on the stream never loses a word.
// Optional build macro DRAIN_CHECKSUM_EN appends one beat holding the 32-bit
// sum of all data words, and moves tlast onto that beat.
module dpram_stream_drain #(
    parameter int P_DPRAM_ADR_WIDTH = 10,
    parameter int P_RD_LAT          = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dpram_run,
    input  logic [15:0]                  dpram_len,
    output logic                         dpram_busy,
    output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
    output logic                         dpram_rden,
    input  logic [31:0]                  dpram_rd_data,
    dpram_stream_drain_if.master         m
);

    localparam int DEPTH = P_RD_LAT + 2;
    localparam int LW    = 17;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = 4;
    localparam logic [LW-1:0] L_MAXLEN = LW'(2 ** P_DPRAM_ADR_WIDTH);
`ifdef DRAIN_CHECKSUM_EN
    localparam logic [LW-1:0] L_EXTRA = LW'(1);
`else
    localparam logic [LW-1:0] L_EXTRA = LW'(0);
`endif

    typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

    state_t                         r_state, w_next;
    logic                           r_busy;
    logic [LW-1:0]                  r_len, r_total, r_issued, r_sent;
    logic [P_DPRAM_ADR_WIDTH-1:0]   r_addr;
    logic [P_RD_LAT-1:0]            r_sr;
    logic [CW-1:0]                  r_inflight, r_count;
    logic [PW-1:0]                  r_wp, r_rp;
    logic [31:0]                    r_mem [DEPTH];

    logic                           w_start, w_rden, w_push, w_wr, w_ck_push;
    logic                           w_valid, w_pop;
    logic [31:0]                    w_wr_data;
    logic [LW-1:0]                  w_len_clamped, w_sent_next;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_start       = (r_state == S_IDLE) && dpram_run;
    assign w_len_clamped = (LW'(dpram_len) > L_MAXLEN) ? L_MAXLEN : LW'(dpram_len);
    assign w_push        = r_sr[P_RD_LAT-1];
    assign w_wr          = w_push || w_ck_push;
    assign w_valid       = (r_count != '0);
    assign w_pop         = w_valid && m.tready;
    assign w_sent_next   = r_sent + LW'(w_pop);

    assign dpram_busy    = r_busy;
    assign dpram_rd_addr = r_addr;
    assign dpram_rden    = w_rden;
    assign m.tvalid      = w_valid;
    assign m.tdata       = w_valid ? r_mem[r_rp] : '0;
    assign m.tlast       = w_valid && (r_sent == r_total - 1'b1);

`ifdef DRAIN_CHECKSUM_EN
    logic [31:0]   r_sum;
    logic          r_ck_done;
    logic [LW-1:0] r_pushed;

    assign w_ck_push = ((r_state == S_READ) || (r_state == S_FLUSH)) && !r_ck_done &&
                       (r_pushed == r_len) && (r_count < CW'(DEPTH));
    assign w_wr_data = w_push ? dpram_rd_data : r_sum;

    // Running sum of data words as they arrive from the DPRAM
    always_ff @(posedge clk) begin
        if (w_start)     r_sum <= '0;
        else if (w_push) r_sum <= r_sum + dpram_rd_data;
    end

    // Track data words received and whether the checksum beat was queued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ck_done <= 1'b0;
            r_pushed  <= '0;
        end else if (w_start) begin
            r_ck_done <= 1'b0;
            r_pushed  <= '0;
        end else begin
            if (w_ck_push) r_ck_done <= 1'b1;
            if (w_push)    r_pushed  <= r_pushed + 1'b1;
        end
    end
`else
    assign w_ck_push = 1'b0;
    assign w_wr_data = dpram_rd_data;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and read-issue decision; reads are throttled so every
    // outstanding word already owns a FIFO slot
    always_comb begin
        w_next = r_state;
        w_rden = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dpram_run) w_next = S_READ;
            end
            S_READ: begin
                w_rden = (r_issued < r_len) && ((r_inflight + r_count) < CW'(DEPTH));
                if (r_issued == r_len) begin
                    w_next = (w_sent_next == r_total) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_sent_next == r_total) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Busy follows the state one cycle late, so it covers READ through DONE
    always_ff @(posedge clk) begin
        if (rst) r_busy <= 1'b0;
        else     r_busy <= (w_next != S_IDLE);
    end

    // Transfer length, issue/address and sent-beat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len    <= '0;
            r_total  <= '0;
            r_issued <= '0;
            r_sent   <= '0;
            r_addr   <= '0;
        end else if (w_start) begin
            r_len    <= w_len_clamped;
            r_total  <= w_len_clamped + L_EXTRA;
            r_issued <= '0;
            r_sent   <= '0;
            r_addr   <= '0;
        end else begin
            if (w_rden) begin
                r_issued <= r_issued + 1'b1;
                r_addr   <= r_addr + 1'b1;
            end
            if (w_pop) r_sent <= w_sent_next;
        end
    end

    // Read-latency tracker, in-flight count and FIFO occupancy/pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wp       <= '0;
            r_rp       <= '0;
        end else begin
            r_sr[0] <= w_rden;
            for (int i = 1; i < P_RD_LAT; i++) r_sr[i] <= r_sr[i-1];
            r_inflight <= r_inflight + CW'(w_rden) - CW'(w_push);
            r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
            if (w_wr)  r_wp <= next_ptr(r_wp);
            if (w_pop) r_rp <= next_ptr(r_rp);
        end
    end

    // FIFO storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= w_wr_data;
    end

endmodule

// File: tb/tb_dpram_stream_drain.sv
// Directed bench for dpram_stream_drain: a table of transfer vectors with
// hand-computed expectations, plus hand-written reset-mid-transfer sequence.
module tb_dpram_stream_drain;

`ifdef DRAIN_CHECKSUM_EN
    localparam int CKX = 1;
`else
    localparam int CKX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dpram_run;
    logic [15:0] dpram_len;
    logic        dpram_busy;
    logic [9:0]  dpram_rd_addr;
    logic        dpram_rden;
    logic [31:0] dpram_rd_data;

    always #5 clk = ~clk;

    dpram_stream_drain_if m_if ();

    dpram_stream_drain #(.P_DPRAM_ADR_WIDTH(10), .P_RD_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .dpram_run     (dpram_run),
        .dpram_len     (dpram_len),
        .dpram_busy    (dpram_busy),
        .dpram_rd_addr (dpram_rd_addr),
        .dpram_rden    (dpram_rden),
        .dpram_rd_data (dpram_rd_data),
        .m             (m_if)
    );

    // DPRAM model, two-cycle read latency
    logic [31:0] ram [0:1023];
    logic [31:0] ram_p1, ram_p2;
    always @(posedge clk) begin
        ram_p1 <= ram[dpram_rd_addr];
        ram_p2 <= ram_p1;
    end
    assign dpram_rd_data = ram_p2;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          n_beats = 0, n_rden = 0, busy_cyc = 0, addr_err = 0, stall_err = 0;
    int          out_cnt = 0, max_out = 0, exp_addr = 0;
    logic [31:0] beat_d [4096];
    logic        beat_l [4096];
    logic        stall_prev = 1'b0;
    logic [31:0] prev_d;
    logic        prev_l;

    always @(negedge clk) begin
        if (rst) begin
            out_cnt    = 0;
            exp_addr   = 0;
            stall_prev = 1'b0;
        end else begin
            if (!dpram_busy) begin
                exp_addr = 0;
                out_cnt  = 0;
            end
            if (dpram_rden) begin
                n_rden++;
                if (dpram_rd_addr != 10'(exp_addr)) addr_err++;
                exp_addr++;
                out_cnt++;
            end
            if (dpram_busy) busy_cyc++;
            if (stall_prev && (!m_if.tvalid || m_if.tdata != prev_d || m_if.tlast != prev_l))
                stall_err++;
            if (m_if.tvalid && m_if.tready) begin
                beat_d[n_beats % 4096] = m_if.tdata;
                beat_l[n_beats % 4096] = m_if.tlast;
                n_beats++;
                out_cnt--;
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            prev_d     = m_if.tdata;
            prev_l     = m_if.tlast;
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fill_ram(input int pat);
        for (int i = 0; i < 1024; i++)
            ram[i] = (i < 4) ? 32'(32'h11111111 * (i + 1)) : 32'hD0000000 + 32'(i);
        if (pat == 1) begin
            ram[0] = 32'hFFFFFFFF;
            ram[1] = 32'h00000002;
            ram[2] = 32'h00000010;
        end
    endtask

    function automatic logic rdy(input int mode, input int c);
        if (mode == 0) return 1'b1;
        return ((c % 4) == 0) || ((c % 4) == 3);
    endfunction

    task automatic do_xfer(input int len, input int mode, input int rerun);
        int cyc;
        @(posedge clk); #1;
        dpram_run   = 1'b1;
        dpram_len   = 16'(len);
        m_if.tready = rdy(mode, 0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            dpram_run   = (rerun != 0) && (cyc == rerun);
            dpram_len   = (cyc == rerun) ? 16'd5 : 16'(len);
            m_if.tready = rdy(mode, cyc);
        end while ((cyc < 2 || dpram_busy) && cyc < 3000);
        dpram_run   = 1'b0;
        m_if.tready = 1'b1;
        chk("xfer_done", 32'(dpram_busy), 32'd0);
    endtask

    typedef struct {
        int          len;
        int          mode;
        int          rerun;
        int          exp_beats;
        int          exp_rden;
        int          exp_busy;
        logic [31:0] exp_lastdata;
        int          pat;
    } vec_t;

    task automatic run_case(input vec_t v);
        int b0, r0, bc0, ae0, se0, nb, lc, dataerr, lastcnt;
        logic [31:0] sum, exp;
        b0 = n_beats; r0 = n_rden; bc0 = busy_cyc; ae0 = addr_err; se0 = stall_err;
        fill_ram(v.pat);
        do_xfer(v.len, v.mode, v.rerun);
        repeat (3) @(posedge clk);
        #1;
        nb = n_beats - b0;
        lc = (v.len > 1024) ? 1024 : v.len;
        chk($sformatf("beats_len%0d", v.len), 32'(nb), 32'(v.exp_beats + CKX));
        chk($sformatf("rden_len%0d", v.len), 32'(n_rden - r0), 32'(v.exp_rden));
        if (v.exp_busy >= 0)
            chk($sformatf("busy_cycles_len%0d", v.len), 32'(busy_cyc - bc0), 32'(v.exp_busy + CKX));
        sum = '0;
        for (int i = 0; i < lc; i++) sum = sum + ram[i];
        dataerr = 0;
        lastcnt = 0;
        for (int i = 0; i < nb && i < 4096; i++) begin
            exp = (i < lc) ? ram[i] : sum;
            if (beat_d[(b0 + i) % 4096] !== exp) dataerr++;
            if (beat_l[(b0 + i) % 4096]) lastcnt++;
        end
        chk($sformatf("data_order_len%0d", v.len), 32'(dataerr), 32'd0);
        chk($sformatf("tlast_count_len%0d", v.len), 32'(lastcnt), (v.exp_beats + CKX > 0) ? 32'd1 : 32'd0);
        if (v.exp_beats + CKX > 0 && nb > 0)
            chk($sformatf("tlast_final_len%0d", v.len), 32'(beat_l[(b0 + nb - 1) % 4096]), 32'd1);
        if (v.exp_beats > 0)
            chk($sformatf("last_data_len%0d", v.len), beat_d[(b0 + lc - 1) % 4096], v.exp_lastdata);
        chk($sformatf("addr_seq_len%0d", v.len), 32'(addr_err - ae0), 32'd0);
        chk($sformatf("stall_stable_len%0d", v.len), 32'(stall_err - se0), 32'd0);
`ifdef DRAIN_CHECKSUM_EN
        if (v.pat == 1) chk("checksum_beat", beat_d[(b0 + 3) % 4096], 32'h00000011);
        if (v.len == 0) chk("checksum_len0", beat_d[b0 % 4096], 32'h00000000);
`endif
    endtask

    vec_t vecs [6];

    initial begin
        //          len  mode rerun beats rden busy  lastdata       pat
        vecs[0] = '{4,    0,   0,    4,    4,   8,   32'h44444444,  0};
        vecs[1] = '{8,    1,   0,    8,    8,  -1,   32'hD0000007,  0};
        vecs[2] = '{0,    0,   0,    0,    0,   2,   32'h00000000,  0};
        vecs[3] = '{2000, 0,   0,    1024, 1024, 1028, 32'hD00003FF, 0};
        vecs[4] = '{16,   0,   5,    16,   16,  20,  32'hD000000F,  0};
        vecs[5] = '{3,    0,   0,    3,    3,   7,   32'h00000010,  1};

        rst         = 1'b1;
        dpram_run   = 1'b0;
        dpram_len   = '0;
        m_if.tready = 1'b0;
        fill_ram(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   32'(dpram_busy),    32'd0);
        chk("rst_rden",   32'(dpram_rden),    32'd0);
        chk("rst_addr",   32'(dpram_rd_addr), 32'd0);
        chk("rst_tvalid", 32'(m_if.tvalid),   32'd0);
        chk("rst_tlast",  32'(m_if.tlast),    32'd0);
        chk("rst_tdata",  m_if.tdata,         32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        m_if.tready = 1'b1;

        for (int k = 0; k < 6; k++) run_case(vecs[k]);

        // Reset in the middle of a len=16 transfer, then a clean len=3 transfer
        fill_ram(0);
        @(posedge clk); #1;
        dpram_run = 1'b1;
        dpram_len = 16'd16;
        @(posedge clk); #1;
        dpram_run = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("busy_before_rst", 32'(dpram_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy",   32'(dpram_busy),  32'd0);
        chk("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        run_case('{3, 0, 0, 3, 3, 7, 32'h33333333, 0});

        chk("fifo_occupancy_le_depth", 32'(max_out <= 4), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpram_stream_drain.md
Name: dpram_stream_drain

Overview:
- Responder/consumer end of the DPRAM handoff used by the waveform buffer reader.
- On a dpram_run pulse it asserts dpram_busy and reads dpram_len 32-bit words from DPRAM port B, starting at address 0.
- Words go out on a 32-bit valid/ready stream toward the readout link; tlast marks the final word.
- dpram_busy drops after the final word has been accepted by the stream consumer, which frees the DPRAM for the next fill.

Parameters:
- P_DPRAM_ADR_WIDTH, 10, DPRAM word address width; depth is 2^P_DPRAM_ADR_WIDTH words.
- P_RD_LAT, 2, DPRAM read latency in cycles from dpram_rden to valid dpram_rd_data; legal values 1..4.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- dpram_run  input  1  single-cycle start pulse from the reader
- dpram_len  input  16  number of 32-bit words to drain; sampled with dpram_run
- dpram_busy  output  1  high while a transfer is in progress
- dpram_rd_addr  output  P_DPRAM_ADR_WIDTH  DPRAM read address
- dpram_rden  output  1  DPRAM read enable
- dpram_rd_data  input  32  DPRAM read data, valid P_RD_LAT cycles after dpram_rden
- m_tdata  output  32  stream data
- m_tvalid  output  1  stream valid
- m_tready  input  1  stream ready
- m_tlast  output  1  marks the final beat of a transfer

Behaviour:
- Reset values: dpram_busy=0, dpram_rden=0, dpram_rd_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0.
- Reset mid-transfer: return to S_IDLE, empty the skid FIFO, drop all in-flight reads. No tlast is emitted.
- States: S_IDLE, S_READ, S_FLUSH, S_DONE.
- S_IDLE:
  - dpram_run=1 latches len_reg = min(dpram_len, 2^P_DPRAM_ADR_WIDTH), sets issue count and address to 0, asserts dpram_busy on the next cycle, and moves to S_READ.
  - dpram_run while busy is ignored.
- S_READ:
  - Assert dpram_rden when issued < len_reg AND (in_flight + fifo_count) < P_RD_LAT+2.
  - Each issue increments the address and the issue count. The address wraps modulo depth (unreachable after the clamp).
  - Move to S_FLUSH once issued == len_reg.
- Skid FIFO:
  - Depth P_RD_LAT+2; captures dpram_rd_data via a P_RD_LAT-deep rden shift register.
  - Head drives m_tdata/m_tvalid. A beat transfers when m_tvalid && m_tready.
  - m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
  - Simultaneous push and pop in the same cycle keeps occupancy unchanged.
- m_tlast: high on the beat whose sent count == len_reg-1.
- S_FLUSH: wait until sent == len_reg, then go to S_DONE.
- S_DONE: deassert dpram_busy (low from the next cycle) and return to S_IDLE.
- Minimum busy width is 2 cycles, including len=0. This guarantees the reader observes busy high.
- len=0: no rden and no beats; busy is high for exactly 2 cycles.
- Latency at m_tready=1, P_RD_LAT=2:
  - run at cycle 0; busy and first rden at cycle 1; first m_tvalid at cycle 4.
  - One word per cycle after that; busy low 2 cycles after the last beat.
- Throughput: 1 word/cycle at sustained m_tready=1, with no bubbles.

Optional Feature:
- Macro: DRAIN_CHECKSUM_EN.
- With the macro defined: after the len_reg data words, one extra beat carries the 32-bit modulo-2^32 sum of all data words.
  - m_tlast moves to the checksum beat.
  - The sum resets at each dpram_run.
  - len=0 emits a single beat, checksum 0x00000000, with tlast=1.
  - Busy drops after the checksum beat transfers.
- Without the macro: no extra beat; tlast is on the last data word; len=0 emits nothing.

Test Plan:
- len=4, DPRAM[0..3]=0x11111111..0x44444444, m_tready=1 -> 4 beats in order, tlast on 0x44444444; busy high from cycle 1 to 2 cycles after the last beat; rden asserted exactly 4 times.
- len=8, m_tready toggling 1,0,0,1 repeating -> all 8 words appear exactly once and in order; m_tdata stable while stalled; FIFO never exceeds P_RD_LAT+2 entries.
- len=0 -> busy high for exactly 2 cycles, no rden and no m_tvalid; with DRAIN_CHECKSUM_EN, one beat 0x00000000 with tlast=1.
- len=2000, P_DPRAM_ADR_WIDTH=10 -> clamped to 1024 beats; addresses 0..1023; tlast on beat 1023.
- dpram_run pulsed again during a len=16 transfer -> ignored; exactly 16 beats. rst asserted mid-transfer -> busy=0 and m_tvalid=0 the next cycle; a following len=3 transfer is clean.
- DRAIN_CHECKSUM_EN, len=3, data 0xFFFFFFFF, 0x00000002, 0x00000010 -> 4th beat 0x00000011 with tlast=1.
